// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared definitions for the PWM generator and PWM capture blocks
// Contents:
//   pwm_state_e  capture FSM states (idle / line high / line low)
//   PWM_VAL_W    default width of the generator duty value
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  localparam int PWM_VAL_W = 8;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for a single asynchronous input
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, both flops clear to 0
//   d_i    asynchronous input
//   q_o    synchronized output (two clk of latency)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures period and high time of a PWM line, flags stuck lines
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   pwm_in      asynchronous PWM input
//   period_cnt  clocks between the last two rising edges (all-ones on timeout)
//   high_cnt    clocks the line was high within that period
//   valid       one-cycle strobe: period_cnt/high_cnt/stuck_* were updated
//   stuck_hi    last report was a timeout with the line held high
//   stuck_lo    last report was a timeout with the line held low
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwm_in,
  output logic [COUNT_W-1:0] period_cnt,
  output logic [COUNT_W-1:0] high_cnt,
  output logic               valid,
  output logic               stuck_hi,
  output logic               stuck_lo
);

  localparam logic [COUNT_W-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_W-1:0] CNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_ZERO = '0;

  logic s;
  logic s_d_q;
  logic rise;
  logic fall;

  pwm_state_e         state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] hcnt_q, hcnt_d;
  logic [COUNT_W-1:0] idle_q, idle_d;
  logic [COUNT_W-1:0] period_q, period_d;
  logic [COUNT_W-1:0] high_q, high_d;
  logic               valid_q, valid_d;
  logic               stuck_hi_q, stuck_hi_d;
  logic               stuck_lo_q, stuck_lo_d;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pwm_in),
    .q_o   (s)
  );

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hcnt_d     = hcnt_q;
    idle_d     = CNT_ZERO;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    stuck_hi_d = stuck_hi_q;
    stuck_lo_d = stuck_lo_q;
    case (state_q)
      ST_IDLE: begin
        idle_d = idle_q + 1'b1;
        if (rise) begin
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
          idle_d  = CNT_ZERO;
          state_d = ST_HIGH;
        end else if (idle_q == CNT_MAX - 1'b1) begin
          // No edge for a full timeout window: report the level the line sits at.
          period_d   = CNT_MAX;
          high_d     = s ? CNT_MAX : CNT_ZERO;
          stuck_hi_d = s;
          stuck_lo_d = ~s;
          valid_d    = 1'b1;
          idle_d     = CNT_ZERO;
        end
      end
      ST_HIGH: begin
        // Timeout wins over a coincident fall: the period never completed.
        if (cnt_q == CNT_MAX) begin
          period_d   = CNT_MAX;
          high_d     = CNT_MAX;
          stuck_hi_d = 1'b1;
          stuck_lo_d = 1'b0;
          valid_d    = 1'b1;
          state_d    = ST_IDLE;
        end else if (fall) begin
          cnt_d   = sat_inc(cnt_q);
          state_d = ST_LOW;
        end else begin
          cnt_d  = sat_inc(cnt_q);
          hcnt_d = sat_inc(hcnt_q);
        end
      end
      ST_LOW: begin
        // A rise closes the period even if cnt has just reached all-ones.
        if (rise) begin
          period_d   = cnt_q;
          high_d     = hcnt_q;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b0;
          valid_d    = 1'b1;
          cnt_d      = CNT_ONE;
          hcnt_d     = CNT_ONE;
          state_d    = ST_HIGH;
        end else if (cnt_q == CNT_MAX) begin
          period_d   = CNT_MAX;
          high_d     = CNT_ZERO;
          stuck_hi_d = 1'b0;
          stuck_lo_d = 1'b1;
          valid_d    = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q      <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= CNT_ZERO;
      hcnt_q     <= CNT_ZERO;
      idle_q     <= CNT_ZERO;
      period_q   <= CNT_ZERO;
      high_q     <= CNT_ZERO;
      valid_q    <= 1'b0;
      stuck_hi_q <= 1'b0;
      stuck_lo_q <= 1'b0;
    end else begin
      s_d_q      <= s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hcnt_q     <= hcnt_d;
      idle_q     <= idle_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      stuck_hi_q <= stuck_hi_d;
      stuck_lo_q <= stuck_lo_d;
    end
  end

  assign period_cnt = period_q;
  assign high_cnt   = high_q;
  assign valid      = valid_q;
  assign stuck_hi   = stuck_hi_q;
  assign stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture against a reference model
module tb_pwm_capture;

  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          pwm_in = 1'b0;
  logic [CW-1:0] period_cnt;
  logic [CW-1:0] high_cnt;
  logic          valid;
  logic          stuck_hi;
  logic          stuck_lo;

  pwm_capture #(.COUNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_in     (pwm_in),
    .period_cnt (period_cnt),
    .high_cnt   (high_cnt),
    .valid      (valid),
    .stuck_hi   (stuck_hi),
    .stuck_lo   (stuck_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int per;
    int hi;
    bit shi;
    bit slo;
  } rep_t;

  int   checks   = 0;
  int   failures = 0;
  int   ecount;
  int   ph_start = 0;
  bit   v_q[$];
  rep_t obs_q[$];
  rep_t exp_q[$];
  rep_t ph_q[$];

  // clock edges since reset release; cycle k is the interval after edge k
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecount <= 0;
    else        ecount <= ecount + 1;
  end

  always @(negedge clk) begin
    rep_t r;
    if (rst_n && valid) begin
      r.cyc = ecount;
      r.per = int'(period_cnt);
      r.hi  = int'(high_cnt);
      r.shi = stuck_hi;
      r.slo = stuck_lo;
      obs_q.push_back(r);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Level seen by the edge detector in cycle k: pwm_in held for edge k-1,
  // after two synchronizer stages, which hold 0 for the first two cycles.
  function automatic bit lvl(input int k);
    if (k >= 2 && (k - 2) < v_q.size()) return v_q[k-2];
    return 1'b0;
  endfunction

  function automatic void add_rep(input int k, input int per, input int hi, input bit shi, input bit slo);
    rep_t r;
    r.cyc = k + 1;
    r.per = per;
    r.hi  = hi;
    r.shi = shi;
    r.slo = slo;
    exp_q.push_back(r);
  endfunction

  // Expected reports from the waveform: a period runs from one rise to the next,
  // high time is the run of 1s after the rise, and any window of MAXV cycles
  // without a completed period produces a stuck report.
  function automatic void build_expected(input int h);
    bit meas, fell, xk, xp, up, dn;
    int r, hi, idle0, age;
    exp_q.delete();
    meas = 0; fell = 0; r = 0; hi = 0; idle0 = 0;
    for (int k = 0; k < h; k++) begin
      xk  = lvl(k);
      xp  = (k > 0) ? lvl(k - 1) : 1'b0;
      up  = xk & ~xp;
      dn  = ~xk & xp;
      age = k - r;
      if (!meas) begin
        if (up) begin
          meas = 1; r = k; fell = 0;
        end else if (k - idle0 == MAXV - 1) begin
          add_rep(k, MAXV, xk ? MAXV : 0, xk, ~xk);
          idle0 = k + 1;
        end
      end else if (!fell) begin
        if (age == MAXV) begin
          add_rep(k, MAXV, MAXV, 1'b1, 1'b0);
          meas = 0; idle0 = k + 1;
        end else if (dn) begin
          fell = 1; hi = age;
        end
      end else begin
        if (up) begin
          add_rep(k, age, hi, 1'b0, 1'b0);
          r = k; fell = 0;
        end else if (age == MAXV) begin
          add_rep(k, MAXV, 0, 1'b0, 1'b1);
          meas = 0; idle0 = k + 1;
        end
      end
    end
  endfunction

  task automatic drive(input bit b);
    pwm_in = b;
    v_q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic pwm_periods(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++) drive(i < hi);
  endtask

  task automatic start_phase(input string tag);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk({tag, "_rst_valid"},  int'(valid),      0);
    chk({tag, "_rst_period"}, int'(period_cnt), 0);
    chk({tag, "_rst_high"},   int'(high_cnt),   0);
    chk({tag, "_rst_shi"},    int'(stuck_hi),   0);
    chk({tag, "_rst_slo"},    int'(stuck_lo),   0);
    v_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    ph_start = obs_q.size();
  endtask

  task automatic finish_phase(input string tag);
    @(negedge clk);
    #1;
    build_expected(v_q.size());
    ph_q.delete();
    for (int i = ph_start; i < obs_q.size(); i++) ph_q.push_back(obs_q[i]);
    chk({tag, "_count"}, ph_q.size(), exp_q.size());
    for (int i = 0; i < ph_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_cyc%0d", tag, i), ph_q[i].cyc, exp_q[i].cyc);
      chk($sformatf("%s_per%0d", tag, i), ph_q[i].per, exp_q[i].per);
      chk($sformatf("%s_hi%0d",  tag, i), ph_q[i].hi,  exp_q[i].hi);
      chk($sformatf("%s_shi%0d", tag, i), int'(ph_q[i].shi), int'(exp_q[i].shi));
      chk($sformatf("%s_slo%0d", tag, i), int'(ph_q[i].slo), int'(exp_q[i].slo));
    end
  endtask

  initial begin
    int per, hi;
    #2;

    // generator-like waveform, duty step mid-run
    start_phase("gen");
    pwm_periods(250, 64, 4);
    pwm_periods(250, 200, 4);
    finish_phase("gen");
    chk("gen_last_per", ph_q.size() > 0 ? ph_q[ph_q.size()-1].per : -1, 250);
    chk("gen_last_hi",  ph_q.size() > 0 ? ph_q[ph_q.size()-1].hi  : -1, 200);

    // random periods and duty
    start_phase("rnd");
    for (int p = 0; p < 40; p++) begin
      per = int'($urandom_range(5, 200));
      hi  = int'($urandom_range(1, per - 1));
      pwm_periods(per, hi, 1);
    end
    finish_phase("rnd");

    // line held low from reset
    start_phase("lo");
    for (int i = 0; i < 520; i++) drive(1'b0);
    finish_phase("lo");
    chk("lo_first_cyc", ph_q.size() > 0 ? ph_q[0].cyc : -1, 255);
    chk("lo_first_slo", ph_q.size() > 0 ? int'(ph_q[0].slo) : -1, 1);
    chk("lo_first_per", ph_q.size() > 0 ? ph_q[0].per : -1, 255);
    chk("lo_first_hi",  ph_q.size() > 0 ? ph_q[0].hi : -1, 0);
    chk("lo_repeat",    ph_q.size() > 1 ? ph_q[1].cyc - ph_q[0].cyc : -1, 255);

    // normal periods, then line sticks high
    start_phase("hi");
    pwm_periods(100, 30, 3);
    for (int i = 0; i < 300; i++) drive(1'b1);
    finish_phase("hi");
    chk("hi_prev_per", ph_q.size() > 1 ? ph_q[ph_q.size()-2].per : -1, 100);
    chk("hi_prev_hi",  ph_q.size() > 1 ? ph_q[ph_q.size()-2].hi : -1, 30);
    chk("hi_last_shi", ph_q.size() > 0 ? int'(ph_q[ph_q.size()-1].shi) : -1, 1);
    chk("hi_last_per", ph_q.size() > 0 ? ph_q[ph_q.size()-1].per : -1, 255);
    chk("hi_last_hi",  ph_q.size() > 0 ? ph_q[ph_q.size()-1].hi : -1, 255);

    // single-cycle pulses
    start_phase("glitch");
    pwm_periods(10, 1, 20);
    finish_phase("glitch");
    chk("glitch_per", ph_q.size() > 0 ? ph_q[ph_q.size()-1].per : -1, 10);
    chk("glitch_hi",  ph_q.size() > 0 ? ph_q[ph_q.size()-1].hi : -1, 1);

    // stop mid-high, then reset
    start_phase("mid");
    pwm_periods(50, 20, 2);
    for (int i = 0; i < 10; i++) drive(1'b1);
    finish_phase("mid");
    chk("mid_pre_rst_per", int'(period_cnt), 50);
    chk("mid_pre_rst_hi",  int'(high_cnt), 20);

    // after reset, the first report needs two fresh rising edges
    start_phase("post");
    pwm_periods(50, 20, 3);
    finish_phase("post");
    chk("post_first_per", ph_q.size() > 0 ? ph_q[0].per : -1, 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
